// File: rtl/core_sequencer.sv
// Sequencer for one core instance: it fills the item memory, streams instructions
// into the core with a one-cycle fetch-to-execute spacing, and waits for lastore to retire.
//
// state   | meaning
// S_IDLE  | waiting for start after reset
// S_GEN   | filling item memory from the random-vector source
// S_RUN   | fetching instructions; exec follows each fetch by one cycle
// S_DRAIN | lastore fetched; waiting for the core's last pulse
// S_DONE  | run finished; done held until start or run=0
module core_sequencer #(
    parameter int NUM_ITEMS = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             run,
    input  logic             start,
    input  logic             gen_en,
    input  logic             rand_valid,
    output logic             rand_ready,
    input  logic             s_valid,
    input  logic [15:0]      s_data,
    output logic             s_ready,
    output logic             gen,
    output logic             update_item,
    output logic [9:0]       item_a,
    output logic             core_run,
    output logic             get_v,
    output logic [15:0]      get_d,
    output logic             exec,
    input  logic             core_last,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] store_count
);

    typedef enum logic [2:0] {S_IDLE, S_GEN, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [9:0] LAST_ITEM = 10'(NUM_ITEMS - 1);

    state_t           r_state;
    state_t           w_next;
    logic [9:0]       r_item_a;
    logic [CNT_W-1:0] r_store_count;
    logic             r_exec;
    logic             w_fetch;
    logic             w_is_lastore;
    logic             w_is_store;
    logic             w_start_ok;

    assign w_is_lastore = (s_data[15:11] == 5'b00000) && s_data[10];
    assign w_is_store   = (s_data[15:12] == 4'b0000) && s_data[11];
    assign w_start_ok   = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // get_v is only ever raised in S_RUN, so it can never overlap gen
    assign w_fetch = (r_state == S_RUN) && s_valid;

    always_comb begin
        w_next      = r_state;
        rand_ready  = 1'b0;
        gen         = 1'b0;
        update_item = 1'b0;
        core_run    = 1'b0;
        s_ready     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                done = (r_state == S_DONE);
                if (start) w_next = gen_en ? S_GEN : S_RUN;
            end
            S_GEN: begin
                gen         = 1'b1;
                rand_ready  = 1'b1;
                update_item = rand_valid;
                busy        = 1'b1;
                if (rand_valid && (r_item_a == LAST_ITEM)) w_next = S_RUN;
            end
            S_RUN: begin
                core_run = 1'b1;
                s_ready  = 1'b1;
                busy     = 1'b1;
                if (w_fetch && w_is_lastore) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                core_run = 1'b1;
                busy     = 1'b1;
                if (core_last) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!run) begin
            r_state       <= S_IDLE;
            r_item_a      <= '0;
            r_store_count <= '0;
            r_exec        <= 1'b0;
        end else begin
            r_state <= w_next;
            r_exec  <= w_fetch;
            if (w_start_ok) begin
                r_item_a      <= '0;
                r_store_count <= '0;
            end else begin
                if ((r_state == S_GEN) && rand_valid)
                    r_item_a <= (r_item_a == LAST_ITEM) ? 10'd0 : r_item_a + 10'd1;
                if (w_fetch && (w_is_store || w_is_lastore) && (r_store_count != '1))
                    r_store_count <= r_store_count + 1'b1;
            end
        end
    end

    assign get_v       = w_fetch;
    assign get_d       = w_fetch ? s_data : 16'h0000;
    assign exec        = r_exec;
    assign item_a      = r_item_a;
    assign store_count = r_store_count;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: reset, item fill, instruction streams with
// bubbles, post-lastore hold, store-count saturation and abort during drain.
module tb_core_sequencer;

    localparam int NUM_ITEMS = 4;
    localparam int CNT_W     = 2;

    logic             clk = 1'b0;
    logic             run = 1'b0;
    logic             start = 1'b0;
    logic             gen_en = 1'b0;
    logic             rand_valid = 1'b1;
    logic             rand_ready;
    logic             s_valid = 1'b1;
    logic [15:0]      s_data = 16'h0800;
    logic             s_ready;
    logic             gen;
    logic             update_item;
    logic [9:0]       item_a;
    logic             core_run;
    logic             get_v;
    logic [15:0]      get_d;
    logic             exec;
    logic             core_last = 1'b0;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] store_count;

    int n_tests = 0;
    int n_fail  = 0;

    core_sequencer #(.NUM_ITEMS(NUM_ITEMS), .CNT_W(CNT_W)) dut (
        .clk(clk), .run(run), .start(start), .gen_en(gen_en),
        .rand_valid(rand_valid), .rand_ready(rand_ready),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .gen(gen), .update_item(update_item), .item_a(item_a),
        .core_run(core_run), .get_v(get_v), .get_d(get_d), .exec(exec),
        .core_last(core_last), .busy(busy), .done(done), .store_count(store_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a run without fill, then feeds words[0..n-1] (last one is lastore),
    // inserting 'gap' idle cycles after each accepted word.
    task automatic run_stream(input logic [15:0] words [8], input int n, input int gap,
                              input bit hold_after, input int exp_cnt);
        int  idx    = 0;
        int  gapc   = 0;
        int  cyc    = 0;
        bit  m_run  = 1'b1;
        bit  m_exec = 1'b0;
        bit  e_getv;
        gen_en  = 1'b0;
        s_valid = 1'b0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        #1;
        check_eq("start_clr_cnt", 32'(store_count), 32'd0);
        check_eq("start_done_low", 32'(done), 32'd0);
        check_eq("start_busy", 32'(busy), 32'd1);
        while (m_run && cyc < 100) begin
            if (gapc > 0) begin
                s_valid = 1'b0;
                gapc--;
            end else begin
                s_valid = 1'b1;
                s_data  = words[idx];
            end
            #1;
            e_getv = s_valid;
            check_eq("run_s_ready", 32'(s_ready), 32'd1);
            check_eq("run_get_v", 32'(get_v), 32'(e_getv));
            check_eq("run_get_d", 32'(get_d), e_getv ? 32'(s_data) : 32'd0);
            check_eq("run_exec", 32'(exec), 32'(m_exec));
            check_eq("run_gen_low", 32'(gen), 32'd0);
            m_exec = e_getv;
            if (e_getv) begin
                if (idx == n - 1) m_run = 1'b0;
                idx++;
                gapc = gap;
            end
            cyc++;
            tick();
        end
        check_eq("stream_bound", 32'(cyc < 100), 32'd1);
        s_valid = hold_after;
        s_data  = 16'h0800;
        #1;
        check_eq("drain_exec", 32'(exec), 32'd1);
        check_eq("drain_s_ready", 32'(s_ready), 32'd0);
        check_eq("drain_get_v", 32'(get_v), 32'd0);
        check_eq("drain_core_run", 32'(core_run), 32'd1);
        tick();
        core_last = 1'b1;
        #1;
        check_eq("drain2_exec", 32'(exec), 32'd0);
        check_eq("drain2_get_v", 32'(get_v), 32'd0);
        check_eq("drain2_done", 32'(done), 32'd0);
        tick();
        core_last = 1'b0;
        #1;
        check_eq("done_flag", 32'(done), 32'd1);
        check_eq("done_busy", 32'(busy), 32'd0);
        check_eq("done_core_run", 32'(core_run), 32'd0);
        check_eq("done_exec", 32'(exec), 32'd0);
        check_eq("done_get_v", 32'(get_v), 32'd0);
        check_eq("done_store_cnt", 32'(store_count), 32'(exp_cnt));
        s_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w [8];
        logic [4:0]  pat;
        int          exp_a;

        // reset with both sources asserting
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_update_item", 32'(update_item), 32'd0);
            check_eq("rst_get_v", 32'(get_v), 32'd0);
        end
        check_eq("rst_gen", 32'(gen), 32'd0);
        check_eq("rst_rand_ready", 32'(rand_ready), 32'd0);
        check_eq("rst_s_ready", 32'(s_ready), 32'd0);
        check_eq("rst_core_run", 32'(core_run), 32'd0);
        check_eq("rst_exec", 32'(exec), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_item_a", 32'(item_a), 32'd0);
        check_eq("rst_get_d", 32'(get_d), 32'd0);
        check_eq("rst_store_cnt", 32'(store_count), 32'd0);

        // fill phase, rand_valid 1,0,1,1,1 (bit 0 first); s_valid held high throughout
        run        = 1'b1;
        rand_valid = 1'b0;
        tick();
        gen_en = 1'b1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        pat   = 5'b11101;
        exp_a = 0;
        for (int i = 0; i < 5; i++) begin
            rand_valid = pat[i];
            #1;
            check_eq("gen_gen", 32'(gen), 32'd1);
            check_eq("gen_rand_ready", 32'(rand_ready), 32'd1);
            check_eq("gen_update_item", 32'(update_item), 32'(pat[i]));
            check_eq("gen_item_a", 32'(item_a), 32'(exp_a));
            check_eq("gen_no_get_v", 32'(get_v), 32'd0);
            check_eq("gen_s_ready", 32'(s_ready), 32'd0);
            if (pat[i]) exp_a++;
            tick();
        end
        rand_valid = 1'b0;
        s_valid    = 1'b0;
        #1;
        check_eq("fill_to_run_s_ready", 32'(s_ready), 32'd1);
        check_eq("fill_to_run_gen", 32'(gen), 32'd0);
        check_eq("fill_to_run_item_a", 32'(item_a), 32'd0);

        // finish the filled run (start while in RUN is ignored)
        w = '{16'h0400, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        run_stream(w, 1, 0, 1'b0, 1);

        // back-to-back stream: load, non-store, store, lastore
        w = '{16'hC005, 16'h1000, 16'h0800, 16'h0400, 16'h0, 16'h0, 16'h0, 16'h0};
        run_stream(w, 4, 0, 1'b0, 2);
        // same stream with two bubble cycles between words
        run_stream(w, 4, 2, 1'b0, 2);
        // source keeps offering a store after lastore
        run_stream(w, 4, 0, 1'b1, 2);
        // five counted words saturate a 2-bit counter at 3
        w = '{16'h0800, 16'h0C00, 16'h0800, 16'h0800, 16'h0400, 16'h0, 16'h0, 16'h0};
        run_stream(w, 5, 1, 1'b0, 3);

        // abort during drain
        gen_en = 1'b0;
        start  = 1'b1;
        tick();
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h0800;
        tick();
        s_data = 16'h0400;
        tick();
        s_valid = 1'b0;
        #1;
        check_eq("abort_pre_exec", 32'(exec), 32'd1);
        check_eq("abort_pre_cnt", 32'(store_count), 32'd2);
        run = 1'b0;
        tick();
        check_eq("abort_exec", 32'(exec), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_core_run", 32'(core_run), 32'd0);
        check_eq("abort_cnt", 32'(store_count), 32'd0);
        run = 1'b1;
        w = '{16'h1000, 16'h0400, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        run_stream(w, 2, 0, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
